// File: rtl/argmax_tree_pkg.sv
// Shared arg-max definitions: default score width, index width and tree shape helpers.
// Nodes pair adjacent survivors; an odd last survivor passes through unchanged.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

package argmax_tree_pkg;

    localparam int ARGMAX_DATA_W_DEF = `DATA_LEN;
    localparam int ARGMAX_PAIR       = 2;

    function automatic int argmax_idx_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Survivor count after s reduction levels.
    function automatic int argmax_lvl_cnt(input int n, input int s);
        int c;
        c = n;
        for (int k = 0; k < s; k++) c = (c + ARGMAX_PAIR - 1) / ARGMAX_PAIR;
        return c;
    endfunction

    // Offset of level s inside a flat array holding every level back to back.
    function automatic int argmax_lvl_off(input int n, input int s);
        int o;
        o = 0;
        for (int k = 0; k < s; k++) o += argmax_lvl_cnt(n, k);
        return o;
    endfunction

    function automatic bit argmax_is_pass(input int n, input int s, input int i);
        return (ARGMAX_PAIR * i + 1) >= argmax_lvl_cnt(n, s - 1);
    endfunction

endpackage

// File: rtl/argmax_tree_if.sv
// Score-vector in / winning-index out stream bundle for argmax_tree.
// q_max is carried only when ARGMAX_MAX_OUT_EN is defined.
interface argmax_tree_if
    import argmax_tree_pkg::*;
#(
    parameter int N_CH   = 12,
    parameter int DATA_W = ARGMAX_DATA_W_DEF,
    parameter int IDX_W  = argmax_idx_w(N_CH)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N_CH*DATA_W-1:0]   d;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         q;
`ifdef ARGMAX_MAX_OUT_EN
    logic signed [DATA_W-1:0] q_max;

    modport slave  (input in_valid, d, out_ready, output in_ready, out_valid, q, q_max);
    modport master (output in_valid, d, out_ready, input in_ready, out_valid, q, q_max);
`else
    modport slave  (input in_valid, d, out_ready, output in_ready, out_valid, q);
    modport master (output in_valid, d, out_ready, input in_ready, out_valid, q);
`endif
endinterface

// File: rtl/argmax_tree_node.sv
// One compare-select tree node: registers the larger of a/b (ties to a) with its index and valid.
// Latency 1; every register holds while adv is low. PASS=1 forwards a unchanged.
module argmax_node #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4,
    parameter bit PASS   = 1'b0,
    parameter bit VAL_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adv,
    input  logic signed [DATA_W-1:0] a_val,
    input  logic [IDX_W-1:0]         a_idx,
    input  logic                     a_vld,
    input  logic signed [DATA_W-1:0] b_val,
    input  logic [IDX_W-1:0]         b_idx,
    input  logic                     b_vld,
    output logic signed [DATA_W-1:0] q_val,
    output logic [IDX_W-1:0]         q_idx,
    output logic                     q_vld
);
    logic                     sel_a;
    logic signed [DATA_W-1:0] val_d, val_q;
    logic [IDX_W-1:0]         idx_d, idx_q;
    logic                     vld_d, vld_q;

    always_comb begin
        sel_a = PASS || (a_val >= b_val);
        val_d = val_q;
        idx_d = idx_q;
        vld_d = vld_q;
        if (adv) begin
            val_d = sel_a ? a_val : b_val;
            idx_d = sel_a ? a_idx : b_idx;
            vld_d = a_vld | b_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            vld_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            vld_q <= vld_d;
        end
    end

    // The final stage only needs its value when the winning score is exported.
    if (VAL_EN) begin : g_val
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) val_q <= '0;
            else        val_q <= val_d;
        end
    end else begin : g_noval
        assign val_q = '0;
    end

    assign q_val = val_q;
    assign q_idx = idx_q;
    assign q_vld = vld_q;
endmodule

// File: rtl/argmax_tree.sv
// Pipelined signed arg-max over N_CH channels, 1-based index out, lowest index wins ties; $clog2(N_CH) cycles.
// Global stall: in_ready = !(out_valid && !out_ready), all stages hold. ARGMAX_MAX_OUT_EN adds q_max.
module argmax_tree
    import argmax_tree_pkg::*;
#(
    parameter int N_CH   = 12,
    parameter int DATA_W = ARGMAX_DATA_W_DEF,
    parameter int IDX_W  = argmax_idx_w(N_CH)
) (
    input logic          clk,
    input logic          rst_n,
    argmax_tree_if.slave bus
);
    localparam int L   = $clog2(N_CH);
    localparam int TOT = argmax_lvl_off(N_CH, L + 1);
`ifdef ARGMAX_MAX_OUT_EN
    localparam bit MAX_OUT = 1'b1;
`else
    localparam bit MAX_OUT = 1'b0;
`endif

    // Every level stored back to back: leaves first, root last.
    logic signed [DATA_W-1:0] val [TOT];
    logic [IDX_W-1:0]         idx [TOT];
    logic                     vld [TOT];
    logic                     adv;

    assign adv          = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;

    for (genvar k = 0; k < N_CH; k++) begin : g_leaf
        assign val[k] = bus.d[k*DATA_W +: DATA_W];
        assign idx[k] = IDX_W'(k + 1);
        assign vld[k] = bus.in_valid;
    end

    for (genvar s = 1; s <= L; s++) begin : g_lvl
        for (genvar i = 0; i < argmax_lvl_cnt(N_CH, s); i++) begin : g_node
            localparam bit PASS = argmax_is_pass(N_CH, s, i);
            localparam int A    = argmax_lvl_off(N_CH, s - 1) + ARGMAX_PAIR * i;
            localparam int B    = PASS ? A : A + 1;
            localparam int O    = argmax_lvl_off(N_CH, s) + i;

            argmax_node #(
                .DATA_W (DATA_W),
                .IDX_W  (IDX_W),
                .PASS   (PASS),
                .VAL_EN ((s < L) || MAX_OUT)
            ) u_node (
                .clk   (clk),
                .rst_n (rst_n),
                .adv   (adv),
                .a_val (val[A]),
                .a_idx (idx[A]),
                .a_vld (vld[A]),
                .b_val (val[B]),
                .b_idx (idx[B]),
                .b_vld (vld[B]),
                .q_val (val[O]),
                .q_idx (idx[O]),
                .q_vld (vld[O])
            );
        end
    end

    assign bus.out_valid = vld[TOT-1];
    assign bus.q         = idx[TOT-1];
`ifdef ARGMAX_MAX_OUT_EN
    assign bus.q_max     = val[TOT-1];
`endif
endmodule

// File: doc/argmax_tree.md
# argmax_tree

Parametrised, pipelined signed arg-max reduction over `N_CH` parallel channels, with a valid/ready stream handshake and a global stall. It takes one vector of class scores per accepted beat and returns the 1-based index of the largest score. It sits at the tail of the network, after the last dense layer. It replaces the fixed 12-input compare tree with arbitrary channel count, deterministic tie-break and backpressure.

## Interface
Parameters:
- `N_CH`, default 12: number of input channels; legal range 2..255.
- `DATA_W`, default `` `data_len ``: signed width of each channel.
- `IDX_W`, default `$clog2(N_CH+1)`: width of the 1-based index.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `d` holds a valid score vector.
- `in_ready`  out  1  block can accept a beat this cycle.
- `d`  in  `N_CH*DATA_W`  signed scores; channel k (0-based) is at `d[k*DATA_W +: DATA_W]`.
- `out_valid`  out  1  `q` holds a valid result.
- `out_ready`  in  1  downstream accepts the result.
- `q`  out  `IDX_W`  1-based winning channel, in the range 1..`N_CH`.
- `q_max`  out  `DATA_W`  winning score; present only with `ARGMAX_MAX_OUT_EN`.

## Operation
- Reduction tree has `L = $clog2(N_CH)` register stages.
- Stage s pairs adjacent survivors of stage s-1 in index order: (0,1), (2,3), …
- When a stage has an odd survivor count, the last survivor is registered through unchanged (pass-through node).
- Each survivor carries a value (`DATA_W`, signed) and an index (`IDX_W`).
- Leaf indices are the constants 1..`N_CH`.
- Compare is two's-complement signed: `a >= b` selects `a`, the lower-index operand.
  - On ties the lowest channel index always wins.
- Valid bits travel in a per-stage shift register beside the data.
- Bubbles are not compressed; a stage is advanced only by the global enable.
- Global enable: `adv = !(out_valid && !out_ready)`.
  - `in_ready = adv`.
  - A beat is accepted when `in_valid && in_ready`.
  - When `adv = 0`, every stage register (data, index, valid) holds.
- When `adv = 1` and `in_valid = 0`, a bubble (valid = 0) enters stage 1.
- Reset: all valid bits, `q` and `q_max` clear to 0.
  - Reset asserted mid-operation discards all in-flight beats.
  - Stalled results are not preserved.
- No width growth: values are selected, never summed.

## Timing
- Latency: a beat accepted at edge t appears with `out_valid = 1` after edge t+`L`, given no stall.
  - `N_CH = 12` gives `L = 4`; `N_CH = 2` gives `L = 1`.
- Throughput: one beat per cycle while `out_ready = 1`.
- `in_ready` is combinational from `out_ready` and `out_valid`; there is no combinational path from `in_valid` to any output.
- `q` and `q_max` are stable while `out_valid && !out_ready`.
- Simultaneous output transfer and input accept in the same cycle is legal and loses no beat.
- After `rst_n` deasserts, `out_valid` stays 0 for at least `L` cycles.

## Configuration
- Macro: `ARGMAX_MAX_OUT_EN`.
- Defined: port `q_max` exists and carries the winning value, aligned with `q`.
- Undefined: port `q_max` is absent.
  - Final-stage value registers are removed.
  - Lower stages keep their value registers, because comparison needs them.
- The index result is identical in both builds.

## Structure
- Default `data_len` comes from the shared `num_data.v`.
- Add `argmax_idx_w(n)` and the pass-through/pairing rule constants there, so the softmax-free classifier and the testbench use the same definitions.
- Sub-module `argmax_node`: a one-pair compare-select with registered value, index and valid, plus hold-on-`!adv`.
  - Parameter `PASS` = 1 selects the pass-through form.
- The top level generates the tree of `argmax_node` instances level by level.

## Test plan
- `N_CH = 12`, d = {-5, 3, 7, 7, 0, …, -128}, single beat → after 4 cycles `q` = 3 (tie with channel 4 resolved low), `q_max` = 7.
- `N_CH = 5` (odd pass-through), d = {-1, -2, -3, -4, 9} → `q` = 5, latency 3.
- Back-to-back 20 random beats with `out_ready` held 1 → 20 results in order, matching a golden signed arg-max with lowest-index ties.
- Hold `out_ready` = 0 for 6 cycles with the pipe full → `in_ready` = 0, `q` is frozen, and no beat is lost or duplicated after release.
- Assert `rst_n` = 0 with 3 beats in flight → `out_valid`, `q` and `q_max` are 0 immediately; the first post-reset beat emerges after exactly `L` cycles.
- All channels = most-negative value (-2^(DATA_W-1)) → `q` = 1.
